// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcode map, control-FSM state encoding and
// the FUNC3 codes the control unit cares about.
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } cu_state_t;

    localparam logic [2:0] FUNC3_CSRRW = 3'b001;

endpackage

// File: rtl/otter_cu_fsm.sv
// Multi-cycle control sequencer for the OTTER core: fetch / exec / writeback /
// interrupt, driving the PC, register-file, memory and CSR enables.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | post-reset hold, RST_OUT asserted for INIT_CYCLES cycles
// ST_FETCH | instruction-port read
// ST_EXEC  | decode opcode, issue enables; LOAD continues to ST_WB
// ST_WB    | load data written to register file, PC advances
// ST_INTR  | interrupt entry, PC loads trap vector
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INTR,
    input  logic [6:0] CU_OPCODE,
    input  logic [2:0] FUNC3,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_WE2,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       RST_OUT,
    output logic [2:0] STATE
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    cu_state_t  state;
    cu_state_t  next_state;
    logic [3:0] init_cnt;
    opcode_t    opcode;

    assign opcode = opcode_t'(CU_OPCODE);
    assign STATE  = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_INIT;
            init_cnt <= 4'd0;
        end else begin
            state <= next_state;
            // Counter only runs while holding in INIT; cleared elsewhere so a
            // recovery from an illegal encoding restarts the full hold.
            if (state == ST_INIT)
                init_cnt <= init_cnt + 4'd1;
            else
                init_cnt <= 4'd0;
        end
    end

    always_comb begin
        next_state = ST_INIT;
        PC_WRITE   = 1'b0;
        REG_WRITE  = 1'b0;
        MEM_WE2    = 1'b0;
        MEM_RDEN1  = 1'b0;
        MEM_RDEN2  = 1'b0;
        CSR_WE     = 1'b0;
        INT_TAKEN  = 1'b0;
        RST_OUT    = 1'b0;

        case (state)
            ST_INIT: begin
                RST_OUT    = 1'b1;
                next_state = (init_cnt == INIT_LAST) ? ST_FETCH : ST_INIT;
            end
            ST_FETCH: begin
                MEM_RDEN1  = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                next_state = INTR ? ST_INTR : ST_FETCH;
                // X or unknown opcodes fall to default and behave as a NOP
                case (opcode)
                    LOAD: begin
                        MEM_RDEN2  = 1'b1;
                        next_state = ST_WB;
                    end
                    STORE: begin
                        MEM_WE2  = 1'b1;
                        PC_WRITE = 1'b1;
                    end
                    LUI, AUIPC, JAL, JALR, OP, OP_IMM: begin
                        PC_WRITE  = 1'b1;
                        REG_WRITE = 1'b1;
                    end
                    SYSTEM: begin
                        PC_WRITE = 1'b1;
                        if (FUNC3 == FUNC3_CSRRW) begin
                            REG_WRITE = 1'b1;
                            CSR_WE    = 1'b1;
                        end
                    end
                    default: PC_WRITE = 1'b1;
                endcase
            end
            ST_WB: begin
                REG_WRITE  = 1'b1;
                PC_WRITE   = 1'b1;
                next_state = INTR ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                INT_TAKEN  = 1'b1;
                PC_WRITE   = 1'b1;
                next_state = ST_FETCH;
            end
            default: next_state = ST_INIT;
        endcase
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed-vector bench for otter_cu_fsm with default and 4-cycle INIT hold.
module tb_otter_cu_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst4 = 1'b1;
    logic       intr = 1'b0;
    logic [6:0] opcode = 7'b0010011;
    logic [2:0] func3 = 3'b000;

    logic pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, csr_we, int_taken, rst_out;
    logic [2:0] state;
    logic pc_write4, reg_write4, mem_we24, mem_rden14, mem_rden24, csr_we4, int_taken4, rst_out4;
    logic [2:0] state4;

    int tests  = 0;
    int failed = 0;

    otter_cu_fsm dut (
        .CLK(clk), .RST(rst), .INTR(intr), .CU_OPCODE(opcode), .FUNC3(func3),
        .PC_WRITE(pc_write), .REG_WRITE(reg_write), .MEM_WE2(mem_we2),
        .MEM_RDEN1(mem_rden1), .MEM_RDEN2(mem_rden2), .CSR_WE(csr_we),
        .INT_TAKEN(int_taken), .RST_OUT(rst_out), .STATE(state)
    );

    otter_cu_fsm #(.INIT_CYCLES(4)) dut4 (
        .CLK(clk), .RST(rst4), .INTR(intr), .CU_OPCODE(opcode), .FUNC3(func3),
        .PC_WRITE(pc_write4), .REG_WRITE(reg_write4), .MEM_WE2(mem_we24),
        .MEM_RDEN1(mem_rden14), .MEM_RDEN2(mem_rden24), .CSR_WE(csr_we4),
        .INT_TAKEN(int_taken4), .RST_OUT(rst_out4), .STATE(state4)
    );

    always #5 clk = ~clk;

    // Output bit order: PC_WRITE REG_WRITE MEM_WE2 MEM_RDEN1 MEM_RDEN2 CSR_WE INT_TAKEN RST_OUT
    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_RST   = 8'b0000_0001;
    localparam logic [7:0] O_FETCH = 8'b0001_0000;
    localparam logic [7:0] O_PCREG = 8'b1100_0000;
    localparam logic [7:0] O_PC    = 8'b1000_0000;
    localparam logic [7:0] O_LOAD  = 8'b0000_1000;
    localparam logic [7:0] O_STORE = 8'b1010_0000;
    localparam logic [7:0] O_CSR   = 8'b1100_0100;
    localparam logic [7:0] O_INTR  = 8'b1000_0010;

    function automatic logic [7:0] outs();
        return {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, csr_we, int_taken, rst_out};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [7:0] o);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".outs"}, 32'(outs()), 32'(o));
    endtask

    initial begin
        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            expect_cycle("reset", 3'd0, O_RST);
        end
        rst = 1'b0;
        #1;
        expect_cycle("init", 3'd0, O_RST);
        step();
        expect_cycle("fetch0", 3'd1, O_FETCH);

        // ADDI
        opcode = 7'b0010011;
        step(); expect_cycle("addi.exec", 3'd2, O_PCREG);
        step(); expect_cycle("addi.fetch", 3'd1, O_FETCH);

        // LW
        opcode = 7'b0000011;
        step(); expect_cycle("lw.exec", 3'd2, O_LOAD);
        step(); expect_cycle("lw.wb", 3'd3, O_PCREG);
        step(); expect_cycle("lw.fetch", 3'd1, O_FETCH);

        // SW with INTR held from fetch
        opcode = 7'b0100011;
        intr   = 1'b1;
        #1;
        expect_cycle("sw.fetch_intr", 3'd1, O_FETCH);
        step(); expect_cycle("sw.exec", 3'd2, O_STORE);
        step(); expect_cycle("sw.intr", 3'd4, O_INTR);
        step(); expect_cycle("sw.no_b2b", 3'd1, O_FETCH);
        intr = 1'b0;

        // CSRRW
        opcode = 7'b1110011;
        func3  = 3'b001;
        step(); expect_cycle("csrrw.exec", 3'd2, O_CSR);
        step(); expect_cycle("csrrw.fetch", 3'd1, O_FETCH);

        // MRET
        func3 = 3'b000;
        step(); expect_cycle("mret.exec", 3'd2, O_PC);
        step(); expect_cycle("mret.fetch", 3'd1, O_FETCH);

        // Unrecognised opcode
        opcode = 7'b1111111;
        step(); expect_cycle("bad.exec", 3'd2, O_PC);
        step(); expect_cycle("bad.fetch", 3'd1, O_FETCH);

        // Branch
        opcode = 7'b1100011;
        step(); expect_cycle("beq.exec", 3'd2, O_PC);
        step(); expect_cycle("beq.fetch", 3'd1, O_FETCH);

        // LW with INTR raised during EXEC: WB first, then interrupt
        opcode = 7'b0000011;
        step(); expect_cycle("lwi.exec", 3'd2, O_LOAD);
        intr = 1'b1;
        step(); expect_cycle("lwi.wb", 3'd3, O_PCREG);
        step(); expect_cycle("lwi.intr", 3'd4, O_INTR);
        intr = 1'b0;
        step(); expect_cycle("lwi.fetch", 3'd1, O_FETCH);

        // Async reset mid STORE EXEC
        opcode = 7'b0100011;
        step(); expect_cycle("swr.exec", 3'd2, O_STORE);
        #2;
        rst = 1'b1;
        #1;
        expect_cycle("swr.async", 3'd0, O_RST);
        step(); expect_cycle("swr.hold", 3'd0, O_RST);
        rst = 1'b0;
        #1;
        expect_cycle("swr.init", 3'd0, O_RST);
        step(); expect_cycle("swr.fetch", 3'd1, O_FETCH);

        // INIT_CYCLES=4 instance: exactly four INIT cycles after release
        step();
        rst4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("init4.state%0d", i), 32'(state4), 32'd0);
            check($sformatf("init4.rst_out%0d", i), 32'(rst_out4), 32'd1);
            step();
        end
        check("init4.fetch", 32'(state4), 32'd1);
        check("init4.rden1", 32'(mem_rden14), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Multi-cycle control state machine for the OTTER RV32I core.
- Sits alongside the combinational CU decoder. It sequences fetch, execute, writeback and interrupt cycles, and drives the write/read enables for the PC, register file, memory and CSR file.
- Produces INT_TAKEN, which the decoder consumes to force the PC source to the interrupt vector.
- Outputs depend on state; in EXEC they also depend on the opcode of the instruction currently latched from memory.

Parameters:
INIT_CYCLES, 1, number of cycles held in ST_INIT after RST deasserts (legal range 1..15)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
INTR  in  1  interrupt request, already masked by MIE upstream; level-sensitive
CU_OPCODE  in  7  instruction bits [6:0]
FUNC3  in  3  instruction bits [14:12]
PC_WRITE  out  1  PC register load enable
REG_WRITE  out  1  register-file write enable
MEM_WE2  out  1  data-port write enable
MEM_RDEN1  out  1  instruction-port read enable
MEM_RDEN2  out  1  data-port read enable
CSR_WE  out  1  CSR file write enable
INT_TAKEN  out  1  interrupt being serviced this cycle; to decoder and CSR (MEPC/MIE save)
RST_OUT  out  1  synchronous reset to PC and register state
STATE  out  3  current state encoding, debug/verification

Behaviour:
- States: ST_INIT=0, ST_FETCH=1, ST_EXEC=2, ST_WB=3, ST_INTR=4. Encodings 5-7 are illegal and go to ST_INIT next cycle.
- RST high: state=ST_INIT and init counter=0 immediately (asynchronous). Outputs are then RST_OUT=1, all others 0, STATE=0.
- ST_INIT:
  - RST_OUT=1; counter increments each cycle while RST is low.
  - Go to ST_FETCH on the edge where counter==INIT_CYCLES-1. With default 1, INIT lasts exactly one cycle after RST release.
- ST_FETCH: MEM_RDEN1=1. Next state is ST_EXEC, unconditionally. INTR is not sampled here.
- ST_EXEC: decode CU_OPCODE.
  - LOAD (0000011): MEM_RDEN2=1, PC_WRITE=0. Next is ST_WB.
  - STORE (0100011): MEM_WE2=1, PC_WRITE=1.
  - BRANCH (1100011): PC_WRITE=1 only.
  - LUI, AUIPC, JAL, JALR, OP, OP_IMM: PC_WRITE=1, REG_WRITE=1.
  - SYSTEM (1110011), FUNC3=001 (CSRRW): PC_WRITE=1, REG_WRITE=1, CSR_WE=1.
  - SYSTEM, any other FUNC3 (MRET): PC_WRITE=1 only.
  - Unrecognised opcode: PC_WRITE=1 only, treated as NOP. No trap.
  - Next state for every non-LOAD opcode: ST_INTR if INTR=1, else ST_FETCH.
- ST_WB: REG_WRITE=1, PC_WRITE=1. Next: ST_INTR if INTR=1, else ST_FETCH.
- ST_INTR: INT_TAKEN=1, PC_WRITE=1. Next is ST_FETCH, unconditionally. INTR is ignored here, so there is no back-to-back INTR.
- Outputs not listed for a state are 0. All outputs are combinational from state and inputs; there are no registered outputs.
- Latency per instruction:
  - 2 cycles normally.
  - 3 cycles for LOAD.
  - +1 cycle when an interrupt is taken.
- INTR is sampled only on the EXEC→next and WB→next edges. A pulse that falls outside those edges is lost; holding INTR until acknowledged is the upstream's responsibility.
- Simultaneous events:
  - INTR during LOAD EXEC: WB completes first, then ST_INTR if INTR is still high.
  - RST mid-instruction: all enables drop in the same cycle. Any pending store is not performed.
- X on CU_OPCODE during ST_EXEC: outputs follow the unrecognised-opcode rule.

Decomposition:
- Shared package otter_pkg holds:
  - opcode_t enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM), shared with the CU decoder.
  - cu_state_t enum (3-bit).
  - FUNC3_CSRRW=3'b001.
- No sub-module: a single always_ff for state and counter, and a single always_comb for next-state and outputs, with defaults assigned at the top.

Test Plan:
- Reset: RST=1 for 3 cycles then released, INIT_CYCLES=1.
  - RST_OUT=1 throughout reset.
  - One ST_INIT cycle after release, then STATE=1 with MEM_RDEN1=1.
- ADDI (OP_IMM 0010011), INTR=0:
  - FETCH then EXEC.
  - In EXEC: PC_WRITE=1, REG_WRITE=1, others 0.
  - STATE sequence 1,2,1.
- LW (0000011):
  - EXEC: MEM_RDEN2=1, PC_WRITE=0.
  - WB: REG_WRITE=1, PC_WRITE=1.
  - STATE sequence 1,2,3,1.
- SW with INTR=1 held from the FETCH cycle:
  - EXEC: MEM_WE2=1, PC_WRITE=1.
  - Then STATE=4 with INT_TAKEN=1, PC_WRITE=1.
  - Then STATE=1 even though INTR stays high.
- CSRRW (1110011, FUNC3=001) gives CSR_WE=1, REG_WRITE=1. MRET (FUNC3=000) gives PC_WRITE=1 only. Opcode 7'b1111111 gives PC_WRITE=1 only.
- RST asserted mid-cycle during a STORE EXEC: MEM_WE2 falls to 0 before the next edge, and STATE=0 immediately. Repeat with INIT_CYCLES=4: exactly 4 INIT cycles after release.
